// File: rtl/sect233k1_pt_check.sv
// On-curve check for sect233k1 (y^2 + xy = x^3 + 1 over GF(2^233)).
// One bit-serial MSB-first multiplier is reused for x^2, x^3 and y(x+y); fixed 700-cycle latency.
module sect233k1_pt_check (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic [232:0] x,
  input  logic [232:0] y,
  output logic         busy,
  output logic         done,
  output logic         on_curve
);

  // f(z) = z^233 + z^74 + 1: bits 74 and 0 fold back when bit 232 shifts out.
  localparam logic [232:0] RedMask = {158'd0, 1'b1, 73'd0, 1'b1};
  localparam logic [7:0]   CntTop  = 8'd232;

  typedef enum logic [2:0] {
    StIdle,
    StMul1,
    StMul2,
    StMul3,
    StCmp
  } state_e;

  state_e       state_q;
  logic [232:0] xr_q;
  logic [232:0] yr_q;
  logic [232:0] t_q;
  logic [232:0] acc_q;
  logic [7:0]   cnt_q;
  logic         busy_q;
  logic         done_q;
  logic         on_curve_q;

  logic [232:0] op_a;
  logic [232:0] op_b;
  logic [232:0] acc_shl;
  logic [232:0] acc_nxt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      StMul1: begin
        op_a = xr_q;
        op_b = xr_q;
      end
      StMul2: begin
        op_a = t_q;
        op_b = xr_q;
      end
      StMul3: begin
        op_a = yr_q;
        op_b = xr_q ^ yr_q;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  always_comb begin
    acc_shl = {acc_q[231:0], 1'b0} ^ (acc_q[232] ? RedMask : '0);
    acc_nxt = acc_shl ^ (op_b[cnt_q] ? op_a : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= StIdle;
      xr_q       <= '0;
      yr_q       <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      on_curve_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            xr_q       <= x;
            yr_q       <= y;
            acc_q      <= '0;
            cnt_q      <= CntTop;
            on_curve_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StMul1;
          end
        end
        StMul1, StMul2: begin
          if (cnt_q == 8'd0) begin
            t_q     <= acc_nxt;
            acc_q   <= '0;
            cnt_q   <= CntTop;
            state_q <= (state_q == StMul1) ? StMul2 : StMul3;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StMul3: begin
          // Final product stays in acc for the compare; t still holds x^3.
          acc_q <= acc_nxt;
          if (cnt_q == 8'd0) begin
            state_q <= StCmp;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StCmp: begin
          on_curve_q <= ((acc_q ^ t_q) == 233'h1);
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign on_curve = on_curve_q;

endmodule

// File: tb/tb_sect233k1_pt_check.sv
// Randomised self-checking bench for sect233k1_pt_check against a polynomial-arithmetic
// model of the curve equation, plus latency, stray-start and abort scenarios.
module tb_sect233k1_pt_check;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         start;
  logic [232:0] x_i;
  logic [232:0] y_i;
  logic         busy;
  logic         done;
  logic         on_curve;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [232:0] Gx = 233'h17232ba853a7e731af129f22ff4149563a419c26bf50a4c9d6eefad6126;
  localparam logic [232:0] Gy = 233'h1db537dece819b7f70f555a67c427a8cd9bf18aeb9b56e0c11056fae6a3;

  sect233k1_pt_check dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (start),
    .x        (x_i),
    .y        (y_i),
    .busy     (busy),
    .done     (done),
    .on_curve (on_curve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [232:0] got, input logic [232:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference field arithmetic: full carry-less product, then reduce top-down.
  function automatic logic [232:0] gf_mul(input logic [232:0] a, input logic [232:0] b);
    logic [465:0] p;
    p = '0;
    for (int i = 0; i < 233; i++) begin
      if (b[i]) p = p ^ ({233'd0, a} << i);
    end
    for (int k = 465; k >= 233; k--) begin
      if (p[k]) begin
        p[k]       = 1'b0;
        p[k - 159] = ~p[k - 159];
        p[k - 233] = ~p[k - 233];
      end
    end
    return p[232:0];
  endfunction

  function automatic logic [232:0] gf_sq(input logic [232:0] a);
    return gf_mul(a, a);
  endfunction

  // a^(2^233 - 2): exponent has bits 232..1 set.
  function automatic logic [232:0] gf_inv(input logic [232:0] a);
    logic [232:0] r;
    r = 233'h1;
    for (int b = 232; b >= 0; b--) begin
      r = gf_sq(r);
      if (b >= 1) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [232:0] half_trace(input logic [232:0] c);
    logic [232:0] h;
    logic [232:0] s;
    h = c;
    s = c;
    for (int i = 1; i <= 116; i++) begin
      s = gf_sq(gf_sq(s));
      h = h ^ s;
    end
    return h;
  endfunction

  function automatic logic model_on_curve(input logic [232:0] px, input logic [232:0] py);
    logic [232:0] lhs;
    logic [232:0] rhs;
    lhs = gf_sq(py) ^ gf_mul(px, py);
    rhs = gf_mul(gf_sq(px), px) ^ 233'h1;
    return lhs == rhs;
  endfunction

  function automatic logic [232:0] rand233();
    logic [255:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return r[232:0];
  endfunction

  // Solve z^2 + z = x + 1/x^2, then y = x*z, for a random x with a solution.
  task automatic gen_point(output logic [232:0] px, output logic [232:0] py);
    logic [232:0] c;
    logic [232:0] z;
    px = Gx;
    py = Gy;
    for (int tries = 0; tries < 60; tries++) begin
      logic [232:0] cx;
      cx = rand233();
      if (cx != '0) begin
        c = cx ^ gf_sq(gf_inv(cx));
        z = half_trace(c);
        if ((gf_sq(z) ^ z) == c) begin
          px = cx;
          py = gf_mul(cx, z);
          break;
        end
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [232:0] px, input logic [232:0] py,
                           input logic expv, input int stray_at);
    int lat;
    int busy_low;
    lat      = 0;
    busy_low = 0;
    @(negedge clk);
    x_i   = px;
    y_i   = py;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_i   = rand233();
    y_i   = rand233();
    for (int n = 1; n <= 800; n++) begin
      if (stray_at != 0 && n == stray_at) begin
        start = 1'b1;
        x_i   = '0;
        y_i   = '0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_low++;
    end
    check({tag, "_latency"}, 233'(lat), 233'd700);
    check({tag, "_busy_low"}, 233'(busy_low), 233'd0);
    check({tag, "_busy_at_done"}, 233'(busy), 233'd1);
    check({tag, "_on_curve"}, 233'(on_curve), 233'(expv));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 233'(done), 233'd0);
    check({tag, "_busy_after"}, 233'(busy), 233'd0);
    check({tag, "_on_curve_held"}, 233'(on_curve), 233'(expv));
  endtask

  task automatic abort_check(input string tag, input logic use_clr, input int at);
    int dones;
    dones = 0;
    @(negedge clk);
    x_i   = Gx;
    y_i   = Gy;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n < at; n++) begin
      @(posedge clk);
      #1;
    end
    if (use_clr) clr = 1'b1;
    else rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;
    check({tag, "_busy"}, 233'(busy), 233'd0);
    check({tag, "_done"}, 233'(done), 233'd0);
    check({tag, "_on_curve"}, 233'(on_curve), 233'd0);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check({tag, "_no_done"}, 233'(dones), 233'd0);
  endtask

  initial begin
    logic [232:0] px;
    logic [232:0] py;
    logic [232:0] fx;
    logic [232:0] fy;
    int           bit_idx;
    int           stray;

    rst   = 1'b1;
    clr   = 1'b0;
    start = 1'b0;
    x_i   = '0;
    y_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 233'(busy), 233'd0);
    check("reset_done", 233'(done), 233'd0);
    check("reset_on_curve", 233'(on_curve), 233'd0);

    run_check("gen", Gx, Gy, 1'b1, 0);
    run_check("gen_y0_flip", Gx, Gy ^ 233'h1, 1'b0, 0);
    run_check("pt_0_1", 233'h0, 233'h1, 1'b1, 0);
    run_check("pt_1_0", 233'h1, 233'h0, 1'b1, 0);
    run_check("pt_1_1", 233'h1, 233'h1, 1'b1, 0);
    run_check("pt_0_0", 233'h0, 233'h0, 1'b0, 0);

    for (int k = 0; k < 3; k++) begin
      gen_point(px, py);
      run_check($sformatf("rnd_pt%0d", k), px, py, model_on_curve(px, py), 0);
      bit_idx = $urandom_range(232, 0);
      fx = px;
      fy = py;
      if (k[0]) fx[bit_idx] = ~fx[bit_idx];
      else fy[bit_idx] = ~fy[bit_idx];
      run_check($sformatf("rnd_bad%0d", k), fx, fy, model_on_curve(fx, fy), 0);
    end

    for (int k = 0; k < 3; k++) begin
      px = rand233();
      py = rand233();
      run_check($sformatf("rnd_pair%0d", k), px, py, model_on_curve(px, py), 0);
    end

    stray = 300;
    run_check("stray_start", Gx, Gy, 1'b1, stray);

    abort_check("rst_400", 1'b0, 400);
    run_check("after_rst", Gx, Gy, 1'b1, 0);
    abort_check("clr_650", 1'b1, 650);
    run_check("after_clr", Gx, Gy, 1'b1, 0);

    repeat (20) @(posedge clk);
    #1;
    check("idle_hold", 233'(on_curve), 233'd1);

    begin
      int saw_busy;
      int saw_done;
      saw_busy = 0;
      saw_done = 0;
      @(negedge clk);
      x_i   = Gx;
      y_i   = Gy;
      start = 1'b1;
      clr   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      clr   = 1'b0;
      check("start_clr_on_curve", 233'(on_curve), 233'd0);
      for (int n = 0; n < 750; n++) begin
        if (busy) saw_busy++;
        if (done) saw_done++;
        @(posedge clk);
        #1;
      end
      check("start_clr_busy", 233'(saw_busy), 233'd0);
      check("start_clr_done", 233'(saw_done), 233'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
